// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM data-memory controller.
// Word accesses are split into a low and a high halfword phase.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } state_e;

  localparam int unsigned DefaultDataBase = 1024;
  localparam int unsigned SramDw          = 16;
  // Wide enough for the largest legal phase length (15 clocks).
  localparam int unsigned TimerW          = 4;

endpackage

// File: rtl/sram_phase_timer.sv
// Counts clocks within a halfword phase and flags the last one; the count returns
// to zero at the end of every phase so the next phase starts fresh.
module sram_phase_timer
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic last
);

  logic [TimerW-1:0] cnt_q, cnt_d;

  always_comb begin
    last  = run && (cnt_q == TimerW'(WAIT_CYCLES - 1));
    cnt_d = cnt_q;
    if (!run || last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// MEM-stage initiator for an external 16-bit asynchronous SRAM: each 32-bit load/store runs as a
// low then a high halfword phase while ready holds the pipeline frozen.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned DATA_BASE   = DefaultDataBase,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        memAdr,
  input  logic [31:0]        writeData,
  input  logic               memRead,
  input  logic               memWrite,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sramAdr,
  output logic [SramDw-1:0]  sramDqOut,
  input  logic [SramDw-1:0]  sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN
);

  state_e              state_q, state_d;
  logic                is_wr_q;
  logic [SramDw-1:0]   wdata_hi_q;
  logic [SRAM_AW-2:0]  word_q;
  logic [SramDw-1:0]   low_buf_q;
  logic                req;
  logic                run;
  logic                last;
  logic [31:0]         offset;
  logic                unused_offset;

  assign req    = memRead | memWrite;
  assign offset = memAdr - DATA_BASE;
  // Byte-offset bits and address bits beyond the SRAM are deliberately dropped.
  assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_phase_timer (
    .clk (clk),
    .rst (rst),
    .run (run),
    .last(last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req)  state_d = StLow;
      StLow:   if (last) state_d = StHigh;
      StHigh:  if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    run      = (state_q == StLow) || (state_q == StHigh);
    ready    = ~req | (state_q == StDone);
    sramDqOe = run && is_wr_q;
    // Strobe released on the final clock so address and data stay valid for hold time.
    sramWeN  = ~(sramDqOe && !last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      is_wr_q    <= 1'b0;
      wdata_hi_q <= '0;
      word_q     <= '0;
      low_buf_q  <= '0;
      readData   <= '0;
      sramAdr    <= '0;
      sramDqOut  <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == StIdle && req) begin
        is_wr_q    <= memWrite;
        wdata_hi_q <= writeData[31:16];
        word_q     <= offset[SRAM_AW:2];
        sramAdr    <= {offset[SRAM_AW:2], 1'b0};
        sramDqOut  <= writeData[15:0];
      end

      if (state_q == StLow && last) begin
        sramAdr   <= {word_q, 1'b1};
        sramDqOut <= wdata_hi_q;
        if (!is_wr_q) begin
          low_buf_q <= sramDqIn;
        end
      end

      if (state_q == StHigh && last && !is_wr_q) begin
        readData <= {sramDqIn, low_buf_q};
      end
    end
  end

endmodule
